// File: rtl/mips_pkg.sv
// Shared definitions for the MIPS pipeline: fetch-stage state encoding,
// NOP / halt words and the word-index width helper.
package mips_pkg;

    typedef enum logic [1:0] {
        IF_IDLE   = 2'd0,
        IF_RUN    = 2'd1,
        IF_HALTED = 2'd2
    } if_state_e;

    localparam logic [31:0] NOP_WORD          = 32'h0000_0000;
    localparam logic [31:0] DEFAULT_HALT_WORD = 32'hFFFF_FFFF;

    function automatic int unsigned word_idx_w(input int unsigned depth);
        return (depth > 1) ? $clog2(depth) : 1;
    endfunction

endpackage

// File: rtl/instruction_memory.sv
// Single-write, synchronous-read instruction store. The read register doubles
// as the IF/ID instruction latch, so it supports hold, load and clear-to-NOP.
module instruction_memory
    import mips_pkg::*;
#(
    parameter int unsigned DATA_WIDTH = 32,
    parameter int unsigned MEM_DEPTH  = 256,
    parameter int unsigned IDX_W      = 8
) (
    input  logic                  clk_i,
    input  logic                  we_i,
    input  logic [IDX_W-1:0]      waddr_i,
    input  logic [DATA_WIDTH-1:0] wdata_i,
    input  logic                  re_i,
    input  logic                  rclr_i,
    input  logic [IDX_W-1:0]      raddr_i,
    output logic [DATA_WIDTH-1:0] rdata_o
);

    logic [DATA_WIDTH-1:0] mem_q [MEM_DEPTH];
    logic [DATA_WIDTH-1:0] rdata_q;

    // Contents are deliberately not reset so a loaded program survives reset.
    always_ff @(posedge clk_i) begin
        if (we_i) mem_q[waddr_i] <= wdata_i;
    end

    always_ff @(posedge clk_i) begin
        if (rclr_i)    rdata_q <= DATA_WIDTH'(NOP_WORD);
        else if (re_i) rdata_q <= mem_q[raddr_i];
    end

    assign rdata_o = rdata_q;

endmodule

// File: rtl/pipelined_instruction_fetch.sv
// IF stage: loader port, IDLE/RUN/HALTED sequencing, PC, and the IF/ID
// register (instruction word lives in the memory read register).
module pipelined_instruction_fetch
    import mips_pkg::*;
#(
    parameter int unsigned           DATA_WIDTH = 32,
    parameter int unsigned           ADDR_WIDTH = 32,
    parameter int unsigned           MEM_DEPTH  = 256,
    parameter logic [ADDR_WIDTH-1:0] RESET_PC   = '0,
    parameter logic [DATA_WIDTH-1:0] HALT_WORD  = DATA_WIDTH'(DEFAULT_HALT_WORD)
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  start,
    input  logic                  mips_enable,
    input  logic                  stall,
    input  logic                  jump,
    input  logic [ADDR_WIDTH-1:0] pc_with_jump,
    input  logic                  write_enable,
    input  logic [ADDR_WIDTH-1:0] address_to_write,
    input  logic [DATA_WIDTH-1:0] instruction_to_write,
    output logic [DATA_WIDTH-1:0] instruction,
    output logic [ADDR_WIDTH-1:0] program_counter,
    output logic                  fetch_valid,
    output logic                  halted
);

    localparam int unsigned           IDX_W   = word_idx_w(MEM_DEPTH);
    localparam logic [ADDR_WIDTH-1:0] PC_STEP = ADDR_WIDTH'(4);

    if_state_e             state_q, state_d, state_eff;
    logic [ADDR_WIDTH-1:0] pc_q, pc_d;
    logic [ADDR_WIDTH-1:0] pc_out_q, pc_out_d;
    logic                  fv_q, fv_d;
    logic                  rd_en, rd_clr, mem_we, halt_seen;
    logic [DATA_WIDTH-1:0] instr;
    logic                  unused_addr_bits;

    // The halt word is only known once it sits in the read register, so the
    // edge that latched it is treated as already HALTED for outputs and control.
    assign halt_seen = (state_q == IF_RUN) && fv_q && (instr == HALT_WORD);
    assign state_eff = halt_seen ? IF_HALTED : state_q;
    assign mem_we    = reset && write_enable && (state_q == IF_IDLE);

    always_comb begin
        state_d  = state_q;
        pc_d     = pc_q;
        pc_out_d = pc_out_q;
        fv_d     = fv_q;
        rd_en    = 1'b0;
        rd_clr   = 1'b0;
        if (!reset) begin
            rd_clr = 1'b1;
        end else if (mips_enable) begin
            case (state_eff)
                IF_IDLE: begin
                    if (start) begin
                        state_d = IF_RUN;
                        pc_d    = RESET_PC;
                    end
                end
                IF_RUN: begin
                    if (jump) begin
                        pc_d   = pc_with_jump;
                        fv_d   = 1'b0;
                        rd_clr = 1'b1;
                    end else if (!stall) begin
                        rd_en    = 1'b1;
                        pc_out_d = pc_q + PC_STEP;
                        pc_d     = pc_q + PC_STEP;
                        fv_d     = 1'b1;
                    end
                end
                IF_HALTED: begin
                    state_d = IF_HALTED;
                    fv_d    = 1'b0;
                    rd_clr  = 1'b1;
                end
                default: state_d = IF_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q  <= IF_IDLE;
            pc_q     <= RESET_PC;
            pc_out_q <= '0;
            fv_q     <= 1'b0;
        end else begin
            state_q  <= state_d;
            pc_q     <= pc_d;
            pc_out_q <= pc_out_d;
            fv_q     <= fv_d;
        end
    end

    instruction_memory #(
        .DATA_WIDTH (DATA_WIDTH),
        .MEM_DEPTH  (MEM_DEPTH),
        .IDX_W      (IDX_W)
    ) u_imem (
        .clk_i   (clk),
        .we_i    (mem_we),
        .waddr_i (address_to_write[IDX_W+1:2]),
        .wdata_i (instruction_to_write),
        .re_i    (rd_en),
        .rclr_i  (rd_clr),
        .raddr_i (pc_q[IDX_W+1:2]),
        .rdata_o (instr)
    );

    // Address bits outside the word index are intentionally ignored (wrap).
    assign unused_addr_bits = ^address_to_write;

    assign instruction     = instr;
    assign program_counter = pc_out_q;
    assign fetch_valid     = fv_q;
    assign halted          = (state_q == IF_HALTED) || halt_seen;

endmodule

// File: doc/pipelined_instruction_fetch.md
# pipelined_instruction_fetch

Parametrised IF stage for the MIPS pipeline, successor to the single-width fetch block. It holds the instruction memory and a program loader port, and sequences IDLE (load) / RUN / HALTED. It fetches one word per cycle into the IF/ID register, with stall hold, jump redirect with wrong-path squash, and halt-word detection. Outputs feed the decode stage directly.

## Interface
- DATA_WIDTH, 32, instruction word width
- ADDR_WIDTH, 32, PC / byte-address width
- MEM_DEPTH, 256, instruction memory depth in words (power of two)
- RESET_PC, 0, byte address fetched first after start
- HALT_WORD, 32'hFFFF_FFFF, instruction that stops fetch
- clk  in  1  sole clock; all logic on rising edge
- reset  in  1  synchronous, active-low
- start  in  1  IDLE->RUN request (level, sampled per edge)
- mips_enable  in  1  global enable; 0 freezes all state except loader writes
- stall  in  1  hazard hold from decode
- jump  in  1  redirect request
- pc_with_jump  in  ADDR_WIDTH  redirect target (byte address)
- write_enable  in  1  loader write strobe
- address_to_write  in  ADDR_WIDTH  loader byte address
- instruction_to_write  in  DATA_WIDTH  loader data
- instruction  out  DATA_WIDTH  IF/ID instruction
- program_counter  out  ADDR_WIDTH  IF/ID PC+4 of that instruction
- fetch_valid  out  1  instruction/program_counter hold a real fetch
- halted  out  1  state is HALTED

## Operation
- States: IDLE, RUN, HALTED. Reset -> IDLE.
- Reset values: pc=RESET_PC, instruction=0, program_counter=0, fetch_valid=0, halted=0. Memory contents not cleared.
- IDLE: write_enable=1 writes mem[address_to_write[log2(MEM_DEPTH)+1:2]] (higher bits ignored, wraps). start=1 -> RUN next edge, pc=RESET_PC. Writes in RUN/HALTED ignored.
- RUN, per edge with mips_enable=1, priority jump > stall > normal:
  - jump: pc<=pc_with_jump; instruction<=0 (NOP), fetch_valid<=0 (squash), program_counter unchanged.
  - stall (no jump): pc, instruction, program_counter, fetch_valid all hold.
  - normal: instruction<=mem[pc word index], program_counter<=pc+4, fetch_valid<=1, pc<=pc+4 (mod 2^ADDR_WIDTH).
- Fetched word == HALT_WORD: it is presented once with fetch_valid=1; state->HALTED same edge; halted=1 from that edge.
- HALTED: pc frozen; next edge fetch_valid<=0, instruction<=0; start, jump, stall ignored; exit only via reset.
- mips_enable=0: state, pc, outputs hold in every state; IDLE loader writes still occur.
- Address beyond MEM_DEPTH words wraps modulo depth; pc itself not truncated.

## Timing
- Fetch latency 1 cycle: pc value at edge N appears on instruction after edge N.
- First valid fetch: edge after the one that sampled start.
- Jump: target word visible 2 edges after jump sampled (1 bubble).
- Stall: zero-latency hold; release resumes with no lost or duplicated fetch.
- Loader write visible to fetch on the next edge (write-first not required; no same-cycle read/write case since states are exclusive).
- reset low mid-RUN/HALTED: all registers to reset values on that edge; outputs valid-low next cycle.

## Structure
- Shared package mips_pkg: state encoding (IF_IDLE, IF_RUN, IF_HALTED), NOP word, default HALT_WORD, word-index helper width.
- One sub-module: instruction_memory (synchronous read, single write port, MEM_DEPTH×DATA_WIDTH); FSM, PC and IF/ID register in the top.

## Test plan
- Load 0x11,0x22,0x33 at bytes 0,4,8, start -> instruction 0x11/0x22/0x33 on consecutive cycles, program_counter 4/8/12, fetch_valid=1.
- Jump to 0x8 while fetching word 0 -> one cycle instruction=0, fetch_valid=0, then 0x33 with program_counter=12.
- Stall 3 cycles after first fetch -> instruction=0x11 held 3 cycles, then 0x22; no skip.
- Write HALT_WORD at byte 8 -> third fetch shows 0xFFFFFFFF valid, halted=1, next cycle fetch_valid=0; later start/jump no effect.
- Write at address 4*MEM_DEPTH+4 (=1028) with value 0xAB -> word 1 reads 0xAB; write during RUN ignored.
- reset low mid-RUN -> next cycle instruction=0, program_counter=0, fetch_valid=0, halted=0, state IDLE; memory retains data, restart refetches 0x11.
